// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage store path: store op codes, bus size codes
// and the layout of one queued store-buffer entry.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_SB  = 3'd0,
    ST_SH  = 3'd1,
    ST_SW  = 3'd2,
    ST_SWL = 3'd3,
    ST_SWR = 3'd4
  } st_op_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Entry address field is sized for the widest supported bus; narrower AW uses the low bits.
  localparam int ENTRY_AW = 32;

  typedef struct packed {
    logic [ENTRY_AW-1:0] addr;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic [1:0]          size;
  } store_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Store-buffer FIFO: DEPTH entries with power-of-two wrapping pointers and an
// occupancy count; the head entry is always visible on the read port.
module sb_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  store_entry_t             push_entry,
  input  logic                     pop,
  output store_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  store_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mem_store_buf.sv
// MEM-stage store buffer: aligns committed stores into strobed bus writes, queues
// them, and drains the queue over the req/addr_ok/data_ok data bus.
module mem_store_buf
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid_i,
  input  logic [2:0]    st_op_i,
  input  logic [AW-1:0] st_addr_i,
  input  logic [31:0]   st_data_i,
  input  logic          st_flush_i,
  output logic          st_stall_o,
  output logic          sb_empty_o,
  output logic          data_req_o,
  output logic          data_wr_o,
  output logic [1:0]    data_size_o,
  output logic [AW-1:0] data_addr_o,
  output logic [3:0]    data_wstrb_o,
  output logic [31:0]   data_wdata_o,
  input  logic          data_addr_ok_i,
  input  logic          data_data_ok_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} bus_state_e;

  bus_state_e    state;
  logic          req_q;
  store_entry_t  new_entry;
  store_entry_t  head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [1:0]    a;
  logic [31:0]   d;

  assign a    = st_addr_i[1:0];
  assign d    = st_data_i;
  assign push = st_valid_i & ~st_flush_i & ~full;
  assign pop  = ((state == S_REQ) & data_addr_ok_i & data_data_ok_i) |
                ((state == S_WAIT) & data_data_ok_i);

  // Word-sized defaults cover SW; the other ops override strobes, data and address alignment.
  always_comb begin
    new_entry.addr  = ENTRY_AW'({st_addr_i[AW-1:2], 2'b00});
    new_entry.wdata = d;
    new_entry.wstrb = 4'b1111;
    new_entry.size  = SIZE_W;
    case (st_op_i)
      ST_SB: begin
        new_entry.addr  = ENTRY_AW'(st_addr_i);
        new_entry.wdata = {4{d[7:0]}};
        new_entry.wstrb = 4'b0001 << a;
        new_entry.size  = SIZE_B;
      end
      ST_SH: begin
        new_entry.addr  = ENTRY_AW'({st_addr_i[AW-1:1], 1'b0});
        new_entry.wdata = {2{d[15:0]}};
        new_entry.wstrb = a[1] ? 4'b1100 : 4'b0011;
        new_entry.size  = SIZE_H;
      end
      ST_SW: begin
      end
      ST_SWL: begin
        case (a)
          2'd0:    begin new_entry.wstrb = 4'b0001; new_entry.wdata = {24'b0, d[31:24]}; end
          2'd1:    begin new_entry.wstrb = 4'b0011; new_entry.wdata = {16'b0, d[31:16]}; end
          2'd2:    begin new_entry.wstrb = 4'b0111; new_entry.wdata = {8'b0, d[31:8]};   end
          default: begin new_entry.wstrb = 4'b1111; new_entry.wdata = d;                 end
        endcase
      end
      ST_SWR: begin
        case (a)
          2'd0:    begin new_entry.wstrb = 4'b1111; new_entry.wdata = d;                 end
          2'd1:    begin new_entry.wstrb = 4'b1110; new_entry.wdata = {d[23:0], 8'b0};   end
          2'd2:    begin new_entry.wstrb = 4'b1100; new_entry.wdata = {d[15:0], 16'b0};  end
          default: begin new_entry.wstrb = 4'b1000; new_entry.wdata = {d[7:0], 24'b0};   end
        endcase
      end
      default: new_entry.wstrb = 4'b0000;
    endcase
  end

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (new_entry),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  // Leaving IDLE on an incoming push gives a one-cycle push-to-request latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      req_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty || push) begin
            state <= S_REQ;
            req_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (data_addr_ok_i && data_data_ok_i && (count > CW'(1))) begin
            state <= S_REQ;
            req_q <= 1'b1;
          end else if (data_addr_ok_i && data_data_ok_i) begin
            state <= S_IDLE;
            req_q <= 1'b0;
          end else if (data_addr_ok_i) begin
            state <= S_WAIT;
            req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (data_data_ok_i && (count > CW'(1))) begin
            state <= S_REQ;
            req_q <= 1'b1;
          end else if (data_data_ok_i) begin
            state <= S_IDLE;
            req_q <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_req_o   = req_q;
  assign data_wr_o    = req_q;
  assign data_size_o  = req_q ? head.size : 2'b00;
  assign data_addr_o  = req_q ? head.addr[AW-1:0] : '0;
  assign data_wstrb_o = req_q ? head.wstrb : 4'b0000;
  assign data_wdata_o = req_q ? head.wdata : 32'h0;

  assign st_stall_o = full;
  assign sb_empty_o = empty & (state == S_IDLE);

endmodule
